// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and load scoreboard for the 8x16 register file.
// Arbitrates the single write port between ALU and load returns. A one-entry
// skid buffer holds a load that loses to the ALU. A starvation counter bounds
// how long that load can wait. The scoreboard stalls issue on RAW/WAW hazards
// against loads that are still outstanding.
module regfile_wb_sched #(
  parameter int WIDTH  = 16,
  parameter int REGS   = 8,
  parameter int IDX    = 3,
  parameter int STARVE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iss_valid,
  input  logic [IDX-1:0]   iss_aindex,
  input  logic [IDX-1:0]   iss_bindex,
  input  logic [IDX-1:0]   iss_yindex,
  input  logic             iss_load,
  output logic             iss_ready,
  input  logic             alu_valid,
  input  logic [IDX-1:0]   alu_index,
  input  logic [WIDTH-1:0] alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [IDX-1:0]   mem_index,
  input  logic [WIDTH-1:0] mem_data,
  output logic             mem_ready,
  output logic             wr_en,
  output logic [IDX-1:0]   wr_index,
  output logic [WIDTH-1:0] wr_data,
  output logic             wr_src_mem,
  output logic [REGS-1:0]  pending,
  output logic             err
);

  localparam int CW = $clog2(STARVE) + 1;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE - 1);

  logic             buf_full;
  logic [IDX-1:0]   buf_index;
  logic [WIDTH-1:0] buf_data;
  logic [CW-1:0]    starve_cnt;

  logic             alu_xfer, mem_xfer, iss_xfer;
  logic             drain, buf_load, buf_full_next, alu_ready_next, err_next;
  logic [CW-1:0]    cnt_next;
  logic [REGS-1:0]  pending_next;

  // A register with an outstanding load blocks any reader or writer of it;
  // there is no bypass from the write-back stage.
  assign iss_ready = !(pending[iss_aindex] | pending[iss_bindex] | pending[iss_yindex]);
  assign mem_ready = !buf_full;

  // Handshakes, buffer/starvation next state, scoreboard update and error detection.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    alu_xfer      = alu_valid && alu_ready;
    mem_xfer      = mem_valid && mem_ready;
    iss_xfer      = iss_valid && iss_ready;
    drain         = buf_full && !alu_xfer;
    buf_load      = mem_xfer && alu_xfer;
    buf_full_next = buf_load || (buf_full && !drain);
    cnt_next      = '0;
    if (buf_full && !drain) cnt_next = starve_cnt + CW'(1);
    // Back-pressure the ALU for one cycle once the buffered load has waited long enough.
    alu_ready_next = !(buf_full_next && (cnt_next >= STARVE_LIM));

    pending_next = pending;
    if (wr_en && wr_src_mem) pending_next[wr_index] = 1'b0;
    if (iss_xfer && iss_load) pending_next[iss_yindex] = 1'b1;

    err_next = err
             | (alu_xfer && pending[alu_index])
             | (mem_xfer && !pending[mem_index])
             | (buf_full && mem_valid && (mem_index == buf_index));
  end

  // Control state, write port and scoreboard; all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_index   <= '0;
      wr_data    <= '0;
      wr_src_mem <= 1'b0;
      pending    <= '0;
      err        <= 1'b0;
      buf_full   <= 1'b0;
      starve_cnt <= '0;
      alu_ready  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      buf_full   <= buf_full_next;
      starve_cnt <= cnt_next;
      alu_ready  <= alu_ready_next;
      pending    <= pending_next;
      err        <= err_next;
      if (alu_xfer) begin
        wr_en      <= 1'b1;
        wr_index   <= alu_index;
        wr_data    <= alu_data;
        wr_src_mem <= 1'b0;
      end else if (buf_full) begin
        wr_en      <= 1'b1;
        wr_index   <= buf_index;
        wr_data    <= buf_data;
        wr_src_mem <= 1'b1;
      end else if (mem_xfer) begin
        wr_en      <= 1'b1;
        wr_index   <= mem_index;
        wr_data    <= mem_data;
        wr_src_mem <= 1'b1;
      end else begin
        wr_en      <= 1'b0;
      end
    end
  end

  // Skid buffer payload captures a load that loses arbitration to the ALU.
  // NOTE: payload is not reset; it is only ever read while buf_full is set.
  always_ff @(posedge clk) begin
    if (buf_load) begin
      buf_index <= mem_index;
      buf_data  <= mem_data;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: load-use stall, ALU/load collision,
// starvation back-pressure, WAW stall, sticky error and asynchronous reset.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_load, iss_ready;
  logic [2:0]  iss_aindex, iss_bindex, iss_yindex;
  logic        alu_valid, alu_ready;
  logic [2:0]  alu_index;
  logic [15:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [2:0]  mem_index;
  logic [15:0] mem_data;
  logic        wr_en, wr_src_mem, err;
  logic [2:0]  wr_index;
  logic [15:0] wr_data;
  logic [7:0]  pending;

  int tests_run = 0;
  int tests_failed = 0;
  logic exp_ar [4];

  regfile_wb_sched #(.WIDTH(16), .REGS(8), .IDX(3), .STARVE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_aindex(iss_aindex), .iss_bindex(iss_bindex),
    .iss_yindex(iss_yindex), .iss_load(iss_load), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_index(alu_index), .alu_data(alu_data),
    .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_index(mem_index), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .wr_src_mem(wr_src_mem), .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs driven afterwards apply to the next cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_load(input logic [2:0] idx);
    iss_valid = 1'b1; iss_load = 1'b1; iss_yindex = idx;
    iss_aindex = 3'd0; iss_bindex = 3'd0;
    step();
    iss_valid = 1'b0; iss_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    iss_valid = 0; iss_load = 0; iss_aindex = 0; iss_bindex = 0; iss_yindex = 0;
    alu_valid = 0; alu_index = 0; alu_data = 0;
    mem_valid = 0; mem_index = 0; mem_data = 0;
    exp_ar[0] = 1'b1; exp_ar[1] = 1'b1; exp_ar[2] = 1'b0; exp_ar[3] = 1'b1;

    // Reset values
    #12;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_index", wr_index, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_src_mem", wr_src_mem, 0);
    check("rst_pending", pending, 0);
    check("rst_err", err, 0);
    check("rst_mem_ready", mem_ready, 1);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_iss_ready", iss_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Load-use stall
    iss_valid = 1; iss_load = 1; iss_yindex = 3; iss_aindex = 0; iss_bindex = 0;
    #1 check("lu_issue_ready", iss_ready, 1);
    step();
    iss_load = 0; iss_yindex = 7; iss_aindex = 3;
    #1 check("lu_pending_set", pending, 8'h08);
    check("lu_stall", iss_ready, 0);
    step(); step();
    check("lu_stall_hold", iss_ready, 0);
    mem_valid = 1; mem_index = 3; mem_data = 16'hBEEF;
    #1 check("lu_mem_ready", mem_ready, 1);
    step();
    mem_valid = 0;
    check("lu_wr_en", wr_en, 1);
    check("lu_wr_index", wr_index, 3);
    check("lu_wr_data", wr_data, 16'hBEEF);
    check("lu_wr_src", wr_src_mem, 1);
    check("lu_no_bypass", iss_ready, 0);
    step();
    check("lu_wr_idle", wr_en, 0);
    check("lu_wr_index_hold", wr_index, 3);
    check("lu_pending_clr", pending, 0);
    check("lu_resume", iss_ready, 1);
    iss_valid = 0; iss_aindex = 0;

    // Collision: ALU wins, load buffered and written next
    issue_load(3'd2);
    alu_valid = 1; alu_index = 1; alu_data = 16'h1111;
    mem_valid = 1; mem_index = 2; mem_data = 16'h2222;
    step();
    alu_valid = 0; mem_valid = 0;
    #1;
    check("col_alu_idx", wr_index, 1);
    check("col_alu_data", wr_data, 16'h1111);
    check("col_alu_src", wr_src_mem, 0);
    check("col_mem_blocked", mem_ready, 0);
    step();
    check("col_buf_en", wr_en, 1);
    check("col_buf_idx", wr_index, 2);
    check("col_buf_data", wr_data, 16'h2222);
    check("col_buf_src", wr_src_mem, 1);
    check("col_mem_ready", mem_ready, 1);
    step();
    check("col_idle", wr_en, 0);
    check("col_pending", pending, 0);
    check("col_err", err, 0);

    // Starvation under continuous ALU traffic
    issue_load(3'd4);
    alu_valid = 1; alu_index = 0; alu_data = 16'hA000;
    mem_valid = 1; mem_index = 4; mem_data = 16'h4444;
    step();
    mem_valid = 0;
    #1 check("stv_buffered", mem_ready, 0);
    check("stv_ready0", alu_ready, 1);
    for (int i = 0; i < 4; i++) begin
      if (alu_ready) alu_data = 16'hA001 + 16'(i);
      step();
      check($sformatf("stv_alu_ready_%0d", i + 1), alu_ready, exp_ar[i]);
      if (i == 2) begin
        check("stv_alu_data", wr_data, 16'hA003);
        check("stv_alu_src", wr_src_mem, 0);
        check("stv_still_full", mem_ready, 0);
      end
      if (i == 3) begin
        check("stv_drain_idx", wr_index, 4);
        check("stv_drain_data", wr_data, 16'h4444);
        check("stv_drain_src", wr_src_mem, 1);
        check("stv_mem_ready", mem_ready, 1);
      end
    end
    alu_valid = 0;
    step();
    check("stv_pending", pending, 0);
    check("stv_err", err, 0);

    // WAW stall
    issue_load(3'd5);
    iss_valid = 1; iss_aindex = 0; iss_bindex = 1; iss_yindex = 5; iss_load = 0;
    #1 check("waw_stall", iss_ready, 0);
    mem_valid = 1; mem_index = 5; mem_data = 16'h5555;
    step();
    mem_valid = 0;
    #1 check("waw_wb_cycle", iss_ready, 0);
    check("waw_wr_index", wr_index, 5);
    step();
    check("waw_release", iss_ready, 1);
    iss_valid = 0; iss_bindex = 0; iss_yindex = 0;

    // Sticky error on load return to a non-pending register
    check("err_before", err, 0);
    mem_valid = 1; mem_index = 6; mem_data = 16'h6666;
    step();
    mem_valid = 0;
    check("err_set", err, 1);
    step(); step();
    check("err_sticky", err, 1);

    // Asynchronous reset with buffer full and pending = 0x18
    issue_load(3'd3);
    issue_load(3'd4);
    alu_valid = 1; alu_index = 0; alu_data = 16'h0BAD;
    mem_valid = 1; mem_index = 3; mem_data = 16'h3333;
    step();
    mem_valid = 0;
    check("ar_buf_full", mem_ready, 0);
    check("ar_pending", pending, 8'h18);
    check("ar_wr_en_pre", wr_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_wr_en", wr_en, 0);
    check("ar_wr_index", wr_index, 0);
    check("ar_wr_data", wr_data, 0);
    check("ar_wr_src", wr_src_mem, 0);
    check("ar_pending_clr", pending, 0);
    check("ar_err_clr", err, 0);
    check("ar_mem_ready", mem_ready, 1);
    check("ar_alu_ready", alu_ready, 1);
    check("ar_iss_ready", iss_ready, 1);
    alu_valid = 0;
    @(negedge clk) rst_n = 1'b1;
    step();
    check("ar_buf_discarded", wr_en, 0);
    check("ar_err_post", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler and load scoreboard for the 8×16 CPU register file. It arbitrates the file's single write port between the ALU write-back path and the memory-load write-back path, and buffers one losing load. It tracks registers with loads still outstanding and stalls the issue stage on RAW and WAW hazards against them. It sits between the execute/memory stages and the register file's yindex/write inputs.

## Interface
- WIDTH, 16, register data width
- REGS, 8, number of architectural registers
- IDX, 3, register index width (log2 REGS)
- STARVE, 4, cycles a buffered load may wait before ALU is back-pressured
- CLK  in  1  system clock, all state on rising edge
- RST_N  in  1  reset, asynchronous assert, active-low
- iss_valid  in  1  issue stage presents an instruction
- iss_aindex / iss_bindex  in  IDX  source operand indices
- iss_yindex  in  IDX  destination index
- iss_load  in  1  instruction is a load (destination becomes pending)
- iss_ready  out  1  issue accepted this cycle (combinational)
- alu_valid  in  1  ALU write-back request
- alu_index  in  IDX  ALU destination
- alu_data  in  WIDTH  ALU result
- alu_ready  out  1  ALU write-back accepted (registered)
- mem_valid  in  1  load-return write-back request
- mem_index  in  IDX  load destination
- mem_data  in  WIDTH  load data
- mem_ready  out  1  load return accepted (= !buf_full)
- wr_en  out  1  register-file write strobe
- wr_index  out  IDX  register-file write index
- wr_data  out  WIDTH  register-file write data
- wr_src_mem  out  1  current write originates from load path
- pending  out  REGS  scoreboard, bit i = load outstanding to ri
- err  out  1  sticky protocol error

## Operation
- Handshakes: a transfer occurs on a rising edge where valid && ready. The ALU and memory paths must hold their request stable while it is not accepted.
- Output stage: wr_en, wr_index, wr_data and wr_src_mem are registered. Each cycle, at most one source is selected:
  - Priority 1: the ALU, when alu_valid && alu_ready.
  - Priority 2: the skid buffer, when full.
  - Priority 3: a direct mem transfer.
  - If nothing is selected, wr_en=0 next cycle and the other write fields hold.
- Skid buffer (1 entry):
  - Loads when a mem transfer occurs and the ALU wins the same edge.
  - Drains when it is selected.
  - mem_ready=0 while full, so no mem transfer is possible on the draining edge.
- Starvation counter:
  - Increments each edge the buffer is full and not drained.
  - Clears on drain.
  - When the count reaches STARVE-1, alu_ready=0 for the next cycle. This forces the drain.
  - alu_ready returns to 1 the cycle after the drain.
- Scoreboard:
  - pending[iss_yindex] sets on an issue transfer with iss_load=1.
  - pending[wr_index] clears at the end of any cycle with wr_en && wr_src_mem, i.e. on the same edge the register file captures the data.
- Hazard: iss_ready = !(pending[aindex] | pending[bindex] | pending[yindex]).
  - There is no bypass; a register whose clear edge is the current edge still stalls this cycle.
  - Set and clear of the same index on one edge is impossible, because the WAW stall prevents it.
- err sets on any of:
  - ALU transfer to a pending index
  - mem transfer to a non-pending index
  - a second mem_valid to the index already held in the buffer

  err clears only on reset.

## Timing
- Reset values:
  - wr_en=0, wr_index=0, wr_data=0, wr_src_mem=0
  - pending=0, err=0
  - buffer empty, starvation counter 0
  - mem_ready=1, alu_ready=1, iss_ready=1 (given an empty scoreboard)
- Latency: transfer at edge N gives wr_en=1 during cycle N+1. The register file holds the new value from edge N+1.
- A buffered load is written 1 cycle after the ALU stops winning. The worst case under continuous ALU traffic is STARVE+1 cycles after acceptance.
- Mem throughput: 1 per cycle with no ALU contention; 1 per 2 cycles under contention.
- Reset mid-operation: the buffered load is discarded and the scoreboard is cleared. The upstream stages are reset together with this block.

## Test plan
- Load-use stall:
  - Stimulus: issue load r3 at edge 1. Present an instruction with aindex=3; iss_ready=0. Mem returns r3=0xBEEF at edge 5.
  - Required: wr_en=1, wr_index=3, wr_data=0xBEEF, wr_src_mem=1 during cycle 6. pending[3]=0 and iss_ready=1 from cycle 7.
- Collision:
  - Stimulus: alu r1=0x1111 and mem r2=0x2222 on the same edge.
  - Required: the ALU write appears the next cycle. mem_ready=0 for one cycle. The r2 write follows immediately after.
- Starvation:
  - Stimulus: ALU valid every cycle; collide a load to r4 with STARVE=4.
  - Required: alu_ready=0 exactly once, 4 cycles after buffering. r4 is written, and alu_ready=1 again the following cycle.
- WAW:
  - Stimulus: pending[5]=1; issue with yindex=5 and sources 0 and 1.
  - Required: iss_ready=0 until the r5 load write-back cycle completes.
- Error flag:
  - Stimulus: mem write to r6 with pending[6]=0.
  - Required: err=1 and it stays 1. Only RST_N low clears it.
- Async reset:
  - Stimulus: assert RST_N low mid-cycle with the buffer full and pending=0x18.
  - Required: all outputs take their reset values immediately, without waiting for a clock edge.
